// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED controller: channel mode codes and width helpers.
// Latency: none (definitions only).
// Backpressure: not applicable.
package led_ctrl_pkg;

    // Mode codes are shared with the host register map and the bench.
    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_t;

    // Width of a field that indexes n items.
    // A single item still needs one bit so that the port exists.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_ctrl_if.sv
// Config write port of the LED controller: channel, mode and duty under valid/ready.
// Latency: none (wiring only).
// Backpressure: the slave holds cfg_ready low until it can accept writes.
interface led_ctrl_if
    import led_ctrl_pkg::*;
#(
    parameter int NUM_LEDS = 4,
    parameter int PWM_BITS = 8
);
    localparam int CHAN_W = idx_width(NUM_LEDS);

    logic                cfg_valid;
    logic                cfg_ready;
    logic [CHAN_W-1:0]   cfg_chan;
    logic [1:0]          cfg_mode;
    logic [PWM_BITS-1:0] cfg_duty;

    modport master (output cfg_valid, cfg_chan, cfg_mode, cfg_duty, input cfg_ready);
    modport slave  (input cfg_valid, cfg_chan, cfg_mode, cfg_duty, output cfg_ready);
endinterface

// File: rtl/led_prescaler.sv
// Shared blink time base: clock divider producing a tick, and a tick counter toggling blink_phase.
// Latency: tick is combinational from div_cnt; blink_phase toggles on the edge ending the last tick of a half-period.
// Backpressure: none, free-running.
module led_prescaler #(
    parameter int DIV         = 10,
    parameter int BLINK_TICKS = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick,
    output logic blink_phase
);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BT_W  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic [BT_W-1:0]  blink_cnt;

    assign tick = (div_cnt == DIV_W'(DIV - 1));

    // Clock divider: counts 0..DIV-1 and wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Blink half-period counter: advances on ticks, toggles the phase on wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (tick) begin
            if (blink_cnt == BT_W'(BLINK_TICKS - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BT_W'(1);
            end
        end
    end
endmodule

// File: rtl/led_ctrl.sv
// Multi-channel LED driver: per-channel OFF/ON/BLINK/PWM with shared free-running blink and PWM counters.
// Latency: a config write takes effect on the pins two edges after acceptance (state edge, then output register).
// Backpressure: cfg_ready is low only during reset and for the first clock after release; afterwards every write is accepted.
module led_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int NUM_LEDS    = 4,
    parameter int PWM_BITS    = 8,
    parameter int CLK_HZ      = 100000000,
    parameter int TICK_HZ     = 1000,
    parameter int BLINK_TICKS = 250,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    led_ctrl_if.slave           cfg,
    output logic [NUM_LEDS-1:0] led
);
    localparam int DIV    = CLK_HZ / TICK_HZ;
    localparam int CHAN_W = idx_width(NUM_LEDS);

    logic                blink_phase;
    logic                ready_q;
    logic                wr_en;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [NUM_LEDS-1:0] lit_vec;

    led_prescaler #(
        .DIV         (DIV),
        .BLINK_TICKS (BLINK_TICKS)
    ) u_prescaler (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (),
        .blink_phase (blink_phase)
    );

    assign cfg.cfg_ready = ready_q;
    assign wr_en         = cfg.cfg_valid & ready_q;

    // Config port opens on the first clock after reset release and stays open.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Free-running PWM phase counter; mode changes never disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // Per-channel storage; writes to channels beyond NUM_LEDS match no slot and are dropped.
    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
        mode_t               mode_q;
        logic [PWM_BITS-1:0] duty_q;
        logic                lit;

        // Mode and duty latch on an accepted write addressed to this channel.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mode_q <= MODE_OFF;
                duty_q <= '0;
            end else if (wr_en && (cfg.cfg_chan == CHAN_W'(i))) begin
                mode_q <= mode_t'(cfg.cfg_mode);
                duty_q <= cfg.cfg_duty;
            end
        end

        // Lit decision from the channel mode and the shared counters.
        always_comb begin
            lit = 1'b0;
            case (mode_q)
                MODE_OFF:   lit = 1'b0;
                MODE_ON:    lit = 1'b1;
                MODE_BLINK: lit = blink_phase;
                MODE_PWM:   lit = (pwm_cnt < duty_q);
                default:    lit = 1'b0;
            endcase
        end

        assign lit_vec[i] = lit;
    end

    // Output register applies pin polarity; reset drives every pin inactive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= {NUM_LEDS{ACTIVE_LOW}};
        end else begin
            led <= lit_vec ^ {NUM_LEDS{ACTIVE_LOW}};
        end
    end
endmodule

// File: tb/tb_led_ctrl.sv
// Bench for led_ctrl: an active-high 4-channel build and an active-low 3-channel build driven with identical writes.
// Latency: expected pin values are queued at each edge and compared on the following falling edge.
// Backpressure: writes are only issued once cfg_ready is expected high.
module tb_led_ctrl;
    import led_ctrl_pkg::*;

    localparam int PB  = 4;
    localparam int DIV = 10;
    localparam int BT  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] led0;
    logic [2:0] led1;

    int errors = 0;
    int checks = 0;

    led_ctrl_if #(.NUM_LEDS(4), .PWM_BITS(PB)) if0 ();
    led_ctrl_if #(.NUM_LEDS(3), .PWM_BITS(PB)) if1 ();

    led_ctrl #(
        .NUM_LEDS(4), .PWM_BITS(PB), .CLK_HZ(1000), .TICK_HZ(100),
        .BLINK_TICKS(BT), .ACTIVE_LOW(1'b0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .cfg(if0), .led(led0)
    );

    led_ctrl #(
        .NUM_LEDS(3), .PWM_BITS(PB), .CLK_HZ(1000), .TICK_HZ(100),
        .BLINK_TICKS(BT), .ACTIVE_LOW(1'b1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .cfg(if1), .led(led1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counters expressed as functions of edges since reset release.
    typedef struct packed {
        logic [3:0] l0;
        logic [2:0] l1;
        logic       rdy;
    } exp_t;

    exp_t       sb_q[$];
    logic [1:0] m_mode[4];
    logic [3:0] m_duty[4];
    int         n_edges;

    function automatic logic model_lit(input int ch, input int n);
        case (m_mode[ch])
            2'd1:    return 1'b1;
            2'd2:    return ((n / (DIV * BT)) % 2) == 1;
            2'd3:    return (n % (1 << PB)) < int'(m_duty[ch]);
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q.delete();
            n_edges = 0;
            for (int i = 0; i < 4; i++) begin
                m_mode[i] = 2'd0;
                m_duty[i] = '0;
            end
        end else begin
            exp_t       e;
            logic [3:0] l;
            for (int i = 0; i < 4; i++) l[i] = model_lit(i, n_edges);
            e.l0  = l;
            e.l1  = ~l[2:0];
            e.rdy = 1'b1;
            sb_q.push_back(e);
            if (if0.cfg_valid && n_edges >= 1) begin
                m_mode[if0.cfg_chan] = if0.cfg_mode;
                m_duty[if0.cfg_chan] = if0.cfg_duty;
            end
            n_edges++;
        end
    end

    // Monitor: reset values while held, queued expectations otherwise.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_led0", {28'd0, led0}, 32'h0);
            chk("rst_led1", {29'd0, led1}, 32'h7);
            chk("rst_ready", {31'd0, if0.cfg_ready}, 32'h0);
        end else if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("led0", {28'd0, led0}, {28'd0, e.l0});
            chk("led1", {29'd0, led1}, {29'd0, e.l1});
            chk("ready0", {31'd0, if0.cfg_ready}, {31'd0, e.rdy});
            chk("ready1", {31'd0, if1.cfg_ready}, {31'd0, e.rdy});
        end
    end

    task automatic drive(input logic [1:0] ch, input logic [1:0] md, input logic [3:0] dt);
        if0.cfg_valid = 1'b1; if0.cfg_chan = ch; if0.cfg_mode = md; if0.cfg_duty = dt;
        if1.cfg_valid = 1'b1; if1.cfg_chan = ch; if1.cfg_mode = md; if1.cfg_duty = dt;
        @(negedge clk);
        if0.cfg_valid = 1'b0;
        if1.cfg_valid = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic random_phase(input int cycles);
        repeat (cycles) begin
            if ($urandom_range(0, 2) == 0)
                drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            else
                idle(1);
        end
    endtask

    initial begin
        int cnt;
        int toggles;
        logic prev;
        logic [3:0] duties[3];
        duties[0] = 4'd0; duties[1] = 4'd4; duties[2] = 4'd15;

        if0.cfg_valid = 1'b0; if0.cfg_chan = '0; if0.cfg_mode = '0; if0.cfg_duty = '0;
        if1.cfg_valid = 1'b0; if1.cfg_chan = '0; if1.cfg_mode = '0; if1.cfg_duty = '0;

        // Reset hold and release.
        idle(3);
        #2 rst_n = 1'b1;
        #1 chk("ready_before_first_edge", {31'd0, if0.cfg_ready}, 32'h0);
        idle(3);

        // ON then OFF on channel 2, with two-edge latency.
        drive(2'd2, MODE_ON, 4'd0);
        chk("on_latency_edge1", {31'd0, led0[2]}, 32'h0);
        @(negedge clk);
        chk("on_latency_edge2", {31'd0, led0[2]}, 32'h1);
        idle(5);
        drive(2'd2, MODE_OFF, 4'd0);
        idle(4);
        chk("off_all_dark", {28'd0, led0}, 32'h0);

        // Blink on channel 0: toggles every 20 clocks.
        drive(2'd0, MODE_BLINK, 4'd0);
        idle(30);
        toggles = 0;
        prev = led0[0];
        repeat (80) begin
            @(negedge clk);
            if (led0[0] != prev) toggles++;
            prev = led0[0];
        end
        chk("blink_toggles_80clk", toggles, 32'd4);
        drive(2'd0, MODE_OFF, 4'd0);

        // PWM duty sweep on channel 1, counted over three periods.
        for (int d = 0; d < 3; d++) begin
            drive(2'd1, MODE_PWM, duties[d]);
            idle(2);
            cnt = 0;
            repeat (48) begin
                @(negedge clk);
                if (led0[1]) cnt++;
            end
            chk("pwm_high_count", cnt, 3 * int'(duties[d]));
        end
        drive(2'd1, MODE_OFF, 4'd0);
        idle(2);

        // Channel 3 is out of range for the 3-channel build.
        drive(2'd3, MODE_ON, 4'd0);
        idle(2);
        chk("bad_chan_ignored", {29'd0, led1}, 32'h7);
        chk("chan3_lit", {28'd0, led0}, 32'h8);
        drive(2'd3, MODE_OFF, 4'd0);

        // Back-to-back writes on consecutive clocks.
        drive(2'd0, MODE_ON, 4'd0);
        drive(2'd1, MODE_ON, 4'd0);
        drive(2'd2, MODE_ON, 4'd0);
        drive(2'd3, MODE_ON, 4'd0);
        idle(2);
        chk("b2b_all_on0", {28'd0, led0}, 32'hF);
        chk("b2b_all_on1", {29'd0, led1}, 32'h0);

        random_phase(300);

        // Reset during the lit phase of a blink.
        for (int c = 0; c < 4; c++) drive(2'(c), MODE_OFF, 4'd0);
        drive(2'd0, MODE_BLINK, 4'd0);
        for (int i = 0; i < 60 && !led0[0]; i++) @(negedge clk);
        chk("blink_lit_seen", {31'd0, led0[0]}, 32'h1);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_led0", {28'd0, led0}, 32'h0);
        chk("async_rst_led1", {29'd0, led1}, 32'h7);
        idle(2);
        #2 rst_n = 1'b1;
        idle(2);
        drive(2'd0, MODE_BLINK, 4'd0);
        idle(100);
        random_phase(200);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
